// File: rtl/data_mem_resp.sv
// Word-organised data memory answering lw/sw requests over a single-outstanding req/ack handshake.
// Define DMEM_BYTE_MASK_EN to add the i_wstrb port and byte-lane write masking.
module data_mem_resp #(
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
`ifdef DMEM_BYTE_MASK_EN
  input  logic [3:0]  i_wstrb,
`endif
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic        o_err,
  output logic        o_busy
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        w_access;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
`ifdef DMEM_BYTE_MASK_EN
  logic [3:0]  r_wstrb;
`endif

  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic              w_acc_we;
  logic [31:0]       w_acc_addr;
  logic [31:0]       w_acc_wdata;
  logic [31:0]       w_addr_hi;
  logic              w_err_next;
  logic [ADDR_W-1:0] w_index;
  logic              w_do_write;
`ifdef DMEM_BYTE_MASK_EN
  logic [3:0]        w_acc_wstrb;
`endif

  // With zero wait states the access happens on the sampling edge, so use the live inputs
  assign w_acc_we    = (r_state == S_IDLE) ? i_we    : r_we;
  assign w_acc_addr  = (r_state == S_IDLE) ? i_addr  : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? i_wdata : r_wdata;
`ifdef DMEM_BYTE_MASK_EN
  assign w_acc_wstrb = (r_state == S_IDLE) ? i_wstrb : r_wstrb;
`endif

  assign w_addr_hi  = w_acc_addr >> (ADDR_W + 2);
  assign w_err_next = (w_acc_addr[1:0] != 2'b00) || (w_addr_hi != 32'd0);
  assign w_index    = w_acc_addr[ADDR_W+1:2];
  assign w_do_write = w_access && rst_n && w_acc_we && !w_err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_access     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_cnt_next = CNT_LOAD;
          if (WAIT_CYCLES == 0) begin
            w_state_next = S_RESP;
            w_access     = 1'b1;
          end else begin
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_RESP;
          w_access     = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
`ifdef DMEM_BYTE_MASK_EN
      r_wstrb <= 4'd0;
`endif
    end else if ((r_state == S_IDLE) && i_req) begin
      r_we    <= i_we;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
`ifdef DMEM_BYTE_MASK_EN
      r_wstrb <= i_wstrb;
`endif
    end
  end

  // err is only ever set on the edge into RESP, so it self-clears with ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_access) begin
      r_err <= w_err_next;
      if (w_err_next) begin
        r_rdata <= 32'd0;
      end else if (!w_acc_we) begin
        r_rdata <= r_mem[w_index];
      end
    end else begin
      r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_write) begin
`ifdef DMEM_BYTE_MASK_EN
      for (int b = 0; b < 4; b++) begin
        if (w_acc_wstrb[b]) begin
          r_mem[w_index][8*b +: 8] <= w_acc_wdata[8*b +: 8];
        end
      end
`else
      r_mem[w_index] <= w_acc_wdata;
`endif
    end
  end

  assign o_rdata = r_rdata;
  assign o_ack   = (r_state == S_RESP);
  assign o_err   = r_err;
  assign o_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: three instances (1, 0 and 3 wait states) checked against a
// behavioural memory model through an expected-response queue.
module tb_data_mem_resp;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
`ifdef DMEM_BYTE_MASK_EN
  logic [3:0]  wstrb;
`endif
  logic [2:0]  req;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [2:0]  busy;
  logic [31:0] rdata [3];

  int          waitOf [3] = '{1, 0, 3};
  logic [31:0] modelMem [3][64];
  logic [31:0] lastRd [3];
  exp_t        sbq [$];
  int          total = 0;
  int          bad = 0;

  data_mem_resp #(.ADDR_W(6), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n), .i_req(req[0]), .i_we(we), .i_addr(addr), .i_wdata(wdata),
`ifdef DMEM_BYTE_MASK_EN
    .i_wstrb(wstrb),
`endif
    .o_rdata(rdata[0]), .o_ack(ack[0]), .o_err(err[0]), .o_busy(busy[0])
  );

  data_mem_resp #(.ADDR_W(6), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n), .i_req(req[1]), .i_we(we), .i_addr(addr), .i_wdata(wdata),
`ifdef DMEM_BYTE_MASK_EN
    .i_wstrb(wstrb),
`endif
    .o_rdata(rdata[1]), .o_ack(ack[1]), .o_err(err[1]), .o_busy(busy[1])
  );

  data_mem_resp #(.ADDR_W(6), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .rst_n(rst_n), .i_req(req[2]), .i_we(we), .i_addr(addr), .i_wdata(wdata),
`ifdef DMEM_BYTE_MASK_EN
    .i_wstrb(wstrb),
`endif
    .o_rdata(rdata[2]), .o_ack(ack[2]), .o_err(err[2]), .o_busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Model the access and queue the response the DUT must give for it
  task automatic pushExpect(input int s, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] strb);
    exp_t        e;
    logic        isErr;
    int          idx;
    logic [31:0] mask;
    isErr = (a[1:0] != 2'b00) || ((a >> 8) != 32'd0);
    idx   = int'(a[7:2]);
    mask  = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    e.err = isErr;
    if (isErr) begin
      lastRd[s] = 32'd0;
    end else if (w) begin
      modelMem[s][idx] = (d & mask) | (modelMem[s][idx] & ~mask);
    end else begin
      lastRd[s] = modelMem[s][idx];
    end
    e.data = lastRd[s];
    sbq.push_back(e);
  endtask

  task automatic doAccess(input int s, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] strb, input string tag);
    exp_t e;
    int   n;
    bit   got;
    pushExpect(s, w, a, d, strb);
    @(negedge clk);
    addr  = a;
    we    = w;
    wdata = d;
`ifdef DMEM_BYTE_MASK_EN
    wstrb = strb;
`endif
    req[s] = 1'b1;
    @(posedge clk);
    n   = 0;
    got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ack[s] === 1'b1) got = 1;
    end
    req[s] = 1'b0;
    e = sbq.pop_front();
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL %s_timeout ack not seen within %0d cycles", tag, n);
    end else begin
      total++;
      if (n !== waitOf[s] + 1) begin
        bad++;
        $display("[TB] FAIL %s_latency got=%0d want=%0d", tag, n, waitOf[s] + 1);
      end
      total++;
      if (err[s] !== e.err) begin
        bad++;
        $display("[TB] FAIL %s_err got=%b want=%b", tag, err[s], e.err);
      end
      total++;
      if (rdata[s] !== e.data) begin
        bad++;
        $display("[TB] FAIL %s_rdata got=%h want=%h", tag, rdata[s], e.data);
      end
    end
    @(negedge clk);
    total++;
    if (ack[s] !== 1'b0 || err[s] !== 1'b0 || busy[s] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_idle got ack=%b err=%b busy=%b want 0/0/0", tag, ack[s], err[s], busy[s]);
    end
  endtask

  task automatic test_reset;
    for (int s = 0; s < 3; s++) begin
      total++;
      if (rdata[s] !== 32'd0 || ack[s] !== 1'b0 || err[s] !== 1'b0 || busy[s] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_values inst=%0d got rdata=%h ack=%b err=%b busy=%b want 0", s,
                 rdata[s], ack[s], err[s], busy[s]);
      end
    end
  endtask

  task automatic test_write_read;
    doAccess(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr_sw10");
    doAccess(0, 1'b0, 32'h10, 32'h0, 4'hF, "wr_lw10");
    doAccess(1, 1'b1, 32'h3C, 32'h0F0F1234, 4'hF, "wr0_sw3c");
    doAccess(1, 1'b0, 32'h3C, 32'h0, 4'hF, "wr0_lw3c");
  endtask

  task automatic test_errors;
    doAccess(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, "err_pre0");
    doAccess(0, 1'b0, 32'h12, 32'h0, 4'hF, "err_lw12");
    doAccess(0, 1'b1, 32'h100, 32'h1, 4'hF, "err_sw100");
    doAccess(0, 1'b0, 32'h0, 32'h0, 4'hF, "err_lw0");
    doAccess(0, 1'b0, 32'hFC, 32'h0, 4'hF, "err_lwtop");
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [4];
    exp_t        e;
    int          cyc;
    int          lastAck;
    int          i;
    addrs = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int k = 0; k < 4; k++) doAccess(1, 1'b1, addrs[k], 32'(k + 1), 4'hF, "b2b_pre");
    pushExpect(1, 1'b0, addrs[0], 32'h0, 4'hF);
    @(negedge clk);
    addr   = addrs[0];
    we     = 1'b0;
    req[1] = 1'b1;
    cyc     = 0;
    lastAck = 0;
    i       = 0;
    while (i < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack[1] === 1'b1) begin
        e = sbq.pop_front();
        total++;
        if (rdata[1] !== e.data || err[1] !== e.err) begin
          bad++;
          $display("[TB] FAIL b2b_data%0d got=%h/%b want=%h/%b", i, rdata[1], err[1], e.data, e.err);
        end
        if (i > 0) begin
          total++;
          if (cyc - lastAck !== 2) begin
            bad++;
            $display("[TB] FAIL b2b_spacing%0d got=%0d want=2", i, cyc - lastAck);
          end
        end
        lastAck = cyc;
        i++;
        if (i < 4) begin
          pushExpect(1, 1'b0, addrs[i], 32'h0, 4'hF);
          addr = addrs[i];
        end else begin
          req[1] = 1'b0;
        end
      end
    end
    req[1] = 1'b0;
    total++;
    if (i !== 4) begin
      bad++;
      $display("[TB] FAIL b2b_count got=%0d want=4", i);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int acks;
    doAccess(2, 1'b1, 32'h20, 32'h11, 4'hF, "rst_pre");
    @(negedge clk);
    addr   = 32'h20;
    we     = 1'b1;
    wdata  = 32'h55;
    req[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (busy[2] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_busy_wait got=%b want=1", busy[2]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (busy[2] !== 1'b0 || ack[2] !== 1'b0 || rdata[2] !== 32'd0) begin
      bad++;
      $display("[TB] FAIL rst_async got busy=%b ack=%b rdata=%h want 0", busy[2], ack[2], rdata[2]);
    end
    req[2] = 1'b0;
    for (int s = 0; s < 3; s++) lastRd[s] = 32'd0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack[2] === 1'b1) acks++;
      if (k == 2) rst_n = 1'b1;
    end
    total++;
    if (acks !== 0) begin
      bad++;
      $display("[TB] FAIL rst_no_ack got=%0d acks want=0", acks);
    end
    doAccess(2, 1'b0, 32'h20, 32'h0, 4'hF, "rst_lw_old");
    doAccess(2, 1'b1, 32'h20, 32'hAA, 4'hF, "rst_swAA");
    doAccess(2, 1'b0, 32'h20, 32'h0, 4'hF, "rst_lwAA");
  endtask

  task automatic test_glitch;
    exp_t        e;
    int          acks;
    logic [31:0] gotData;
    logic        gotErr;
    doAccess(0, 1'b1, 32'h8, 32'h0BADCAFE, 4'hF, "gl_pre8");
    doAccess(0, 1'b1, 32'h4, 32'h12345678, 4'hF, "gl_pre4");
    pushExpect(0, 1'b0, 32'h8, 32'h0, 4'hF);
    @(negedge clk);
    addr   = 32'h8;
    we     = 1'b0;
    req[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    addr   = 32'h4;
    we     = 1'b1;
    wdata  = 32'hFFFFFFFF;
    req[0] = 1'b0;
    acks    = 0;
    gotData = 32'h0;
    gotErr  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (ack[0] === 1'b1) begin
        if (acks == 0) begin
          gotData = rdata[0];
          gotErr  = err[0];
        end
        acks++;
      end
      @(negedge clk);
    end
    e = sbq.pop_front();
    total++;
    if (acks !== 1) begin
      bad++;
      $display("[TB] FAIL gl_ackcount got=%0d want=1", acks);
    end
    total++;
    if (gotData !== e.data || gotErr !== e.err) begin
      bad++;
      $display("[TB] FAIL gl_data got=%h/%b want=%h/%b", gotData, gotErr, e.data, e.err);
    end
    doAccess(0, 1'b0, 32'h4, 32'h0, 4'hF, "gl_lw4");
  endtask

`ifdef DMEM_BYTE_MASK_EN
  task automatic test_byte_mask;
    doAccess(0, 1'b1, 32'h0, 32'h11223344, 4'hF, "bm_pre");
    doAccess(0, 1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, "bm_sw0101");
    doAccess(0, 1'b0, 32'h0, 32'h0, 4'hF, "bm_lw");
    doAccess(0, 1'b1, 32'h0, 32'h99999999, 4'b0000, "bm_sw0000");
    doAccess(0, 1'b0, 32'h0, 32'h0, 4'hF, "bm_lw2");
    doAccess(0, 1'b1, 32'h2, 32'hFFFFFFFF, 4'b1100, "bm_misalign");
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    req   = 3'b000;
    we    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
`ifdef DMEM_BYTE_MASK_EN
    wstrb = 4'hF;
`endif
    for (int s = 0; s < 3; s++) begin
      lastRd[s] = 32'd0;
      for (int k = 0; k < 64; k++) modelMem[s][k] = 32'd0;
    end
    #3;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_write_read;
    test_errors;
    test_back_to_back;
    test_reset_abort;
    test_glitch;
`ifdef DMEM_BYTE_MASK_EN
    test_byte_mask;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
